// File: rtl/i2c_reg_sequencer_if.sv
// Command/response and byte-controller signal bundle for the register sequencer.
// The master side is the sequencer itself; the slave side is its environment.
interface i2c_reg_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [6:0]  cmd_dev;
  logic [7:0]  cmd_reg;
  logic [1:0]  cmd_len;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        ctl_start;
  logic        ctl_stop;
  logic        ctl_rwbit;
  logic [6:0]  ctl_periph;
  logic [7:0]  ctl_tx;
  logic        ctl_busy;
  logic        ctl_loading;
  logic        ctl_starting;
  logic        ctl_nack;
  logic [7:0]  ctl_rx;

  modport master (
    input  cmd_valid, cmd_read, cmd_dev, cmd_reg, cmd_len, cmd_wdata,
    input  ctl_busy, ctl_loading, ctl_starting, ctl_nack, ctl_rx,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    output ctl_start, ctl_stop, ctl_rwbit, ctl_periph, ctl_tx
  );

  modport slave (
    output cmd_valid, cmd_read, cmd_dev, cmd_reg, cmd_len, cmd_wdata,
    output ctl_busy, ctl_loading, ctl_starting, ctl_nack, ctl_rx,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    input  ctl_start, ctl_stop, ctl_rwbit, ctl_periph, ctl_tx
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Expands one register-level read/write command into the byte-by-byte drive of
// the I2C byte controller and returns read data with an error flag.
module i2c_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  i2c_reg_sequencer_if.master bus
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LAUNCH, S_ADDR_W, S_REG, S_WDATA, S_RESTART,
    S_ADDR_R, S_RDATA, S_DRAIN, S_FAIL, S_RESP
  } state_t;

  state_t        state_q;
  logic [11:0]   meta_q, sync_q;
  logic          loading_q, busy_q;
  logic [CW-1:0] cnt_q;
  logic          read_q, err_q;
  logic [1:0]    len_q, idx_q;
  logic [7:0]    reg_q;
  logic [31:0]   wdata_q, rdata_q;
  logic          cmd_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q;
  logic          ctl_start_q, ctl_stop_q, ctl_rwbit_q;
  logic [6:0]    ctl_periph_q;
  logic [7:0]    ctl_tx_q;

  logic       busy_s, loading_s, starting_s, nack_s;
  logic [7:0] rx_s;
  logic       load_rise, busy_fall, expired, accept, active;
  logic [1:0] idx_inc;

  assign {busy_s, loading_s, starting_s, nack_s, rx_s} = sync_q;
  assign load_rise = loading_s & ~loading_q;
  assign busy_fall = busy_q & ~busy_s;
  assign expired   = (cnt_q == CW'(TIMEOUT_CYCLES));
  assign accept    = bus.cmd_valid & cmd_ready_q;
  assign idx_inc   = idx_q + 2'd1;
  // States in which the controller must still be busy on our behalf
  assign active    = state_q inside {S_LAUNCH, S_ADDR_W, S_REG, S_WDATA, S_RESTART, S_ADDR_R};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      meta_q       <= '0;
      sync_q       <= '0;
      loading_q    <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      read_q       <= 1'b0;
      err_q        <= 1'b0;
      len_q        <= '0;
      idx_q        <= '0;
      reg_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      ctl_start_q  <= 1'b0;
      ctl_stop_q   <= 1'b0;
      ctl_rwbit_q  <= 1'b0;
      ctl_periph_q <= '0;
      ctl_tx_q     <= '0;
    end else begin
      meta_q      <= {bus.ctl_busy, bus.ctl_loading, bus.ctl_starting, bus.ctl_nack, bus.ctl_rx};
      sync_q      <= meta_q;
      loading_q   <= loading_s;
      busy_q      <= busy_s;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= (state_q == S_IDLE) && !accept;
      if (state_q == S_IDLE || state_q == S_RESP || load_rise) cnt_q <= '0;
      else                                                      cnt_q <= cnt_q + 1'b1;

      if (active && busy_fall) begin
        err_q   <= 1'b1;
        cnt_q   <= '0;
        state_q <= S_RESP;
      end else if (active && expired) begin
        err_q       <= 1'b1;
        ctl_start_q <= 1'b0;
        ctl_stop_q  <= 1'b1;
        cnt_q       <= '0;
        state_q     <= S_FAIL;
      end else begin
        case (state_q)
          S_IDLE: if (accept) begin
            read_q       <= bus.cmd_read;
            len_q        <= bus.cmd_len;
            reg_q        <= bus.cmd_reg;
            wdata_q      <= bus.cmd_wdata;
            rdata_q      <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            ctl_periph_q <= bus.cmd_dev;
            ctl_rwbit_q  <= 1'b0;
            ctl_start_q  <= 1'b1;
            state_q      <= S_LAUNCH;
          end
          S_LAUNCH, S_RESTART: if (starting_s) begin
            ctl_start_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= (state_q == S_LAUNCH) ? S_ADDR_W : S_ADDR_R;
          end
          S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: if (load_rise) begin
            if (nack_s) begin
              err_q       <= 1'b1;
              ctl_start_q <= 1'b0;
              ctl_stop_q  <= 1'b1;
              state_q     <= S_FAIL;
            end else if (state_q == S_ADDR_W) begin
              ctl_tx_q <= reg_q;
              state_q  <= S_REG;
            end else if (state_q == S_REG && read_q) begin
              ctl_rwbit_q <= 1'b1;
              ctl_start_q <= 1'b1;
              state_q     <= S_RESTART;
            end else if (state_q == S_REG) begin
              ctl_tx_q <= wdata_q[7:0];
              state_q  <= S_WDATA;
            end else if (state_q == S_ADDR_R) begin
              if (len_q == 2'd0) ctl_stop_q <= 1'b1;
              state_q <= S_RDATA;
            end else if (idx_q == len_q) begin
              ctl_stop_q <= 1'b1;
              state_q    <= S_DRAIN;
            end else begin
              idx_q    <= idx_inc;
              ctl_tx_q <= wdata_q[{idx_inc, 3'b000} +: 8];
            end
          end
          S_RDATA: begin
            // The last byte has no load window; it is taken as the bus goes idle
            if (busy_fall) begin
              rdata_q[{len_q, 3'b000} +: 8] <= rx_s;
              cnt_q   <= '0;
              state_q <= S_RESP;
            end else if (expired) begin
              err_q       <= 1'b1;
              ctl_stop_q  <= 1'b1;
              cnt_q       <= '0;
              state_q     <= S_FAIL;
            end else if (load_rise && idx_q != len_q) begin
              rdata_q[{idx_q, 3'b000} +: 8] <= rx_s;
              idx_q <= idx_inc;
              if (idx_inc == len_q) ctl_stop_q <= 1'b1;
            end
          end
          S_DRAIN: if (!busy_s || expired) begin
            if (expired) err_q <= 1'b1;
            state_q <= S_RESP;
          end
          S_FAIL: if (!busy_s || expired) state_q <= S_RESP;
          S_RESP: begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rsp_rdata_q <= err_q ? 32'd0 : rdata_q;
            ctl_stop_q  <= 1'b0;
            ctl_rwbit_q <= 1'b0;
            state_q     <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.ctl_start  = ctl_start_q;
  assign bus.ctl_stop   = ctl_stop_q;
  assign bus.ctl_rwbit  = ctl_rwbit_q;
  assign bus.ctl_periph = ctl_periph_q;
  assign bus.ctl_tx     = ctl_tx_q;
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench: a behavioural byte controller logs every bus byte against an
// expected queue, and a response monitor pops expected {err, rdata} words.
`timescale 1ns/1ps
module tb_i2c_reg_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_reg_sequencer_if bus();
  i2c_reg_sequencer #(.TIMEOUT_CYCLES(1000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam int SR = 256;
  localparam int PSTOP = 512;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  int load_cnt = 0;
  logic [32:0] exp_rsp_q[$];
  int          exp_bus_q[$];
  logic        hang_mode = 1'b0;
  logic [7:0]  slave_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic log_bus(input int b);
    int e;
    e = (exp_bus_q.size() != 0) ? exp_bus_q.pop_front() : -1;
    check("bus_byte", 64'(b), 64'(e));
  endtask

  // Behavioural byte controller with slaves at 0x50 and 0x68
  typedef enum {M_IDLE, M_START, M_SHIFT, M_LOAD, M_RSHIFT, M_STOP, M_HANG} mst_t;
  mst_t m_st;
  int   m_cnt;
  int   m_k;
  logic m_read;
  logic m_addr;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= M_IDLE; m_cnt <= 0; m_k <= 0; m_read <= 1'b0; m_addr <= 1'b0;
      bus.ctl_busy <= 1'b0; bus.ctl_loading <= 1'b0; bus.ctl_starting <= 1'b0;
      bus.ctl_nack <= 1'b0; bus.ctl_rx <= 8'h00;
    end else begin
      case (m_st)
        M_IDLE: if (bus.ctl_start) begin
          bus.ctl_busy <= 1'b1; bus.ctl_starting <= 1'b1; bus.ctl_nack <= 1'b0;
          m_cnt <= 0; m_st <= M_START;
        end
        M_START: if (m_cnt == 2) begin
          bus.ctl_starting <= 1'b0; m_cnt <= 0;
          if (hang_mode) m_st <= M_HANG;
          else begin
            log_bus({bus.ctl_periph, bus.ctl_rwbit});
            m_read <= bus.ctl_rwbit; m_k <= 0; m_addr <= 1'b1; m_st <= M_SHIFT;
          end
        end else m_cnt <= m_cnt + 1;
        M_SHIFT: if (m_cnt == 5) begin
          bus.ctl_loading <= 1'b1;
          bus.ctl_nack <= m_addr && !(bus.ctl_periph == 7'h50 || bus.ctl_periph == 7'h68);
          load_cnt <= load_cnt + 1; m_cnt <= 0; m_st <= M_LOAD;
        end else m_cnt <= m_cnt + 1;
        M_LOAD: if (m_cnt == 5) begin
          bus.ctl_loading <= 1'b0; m_cnt <= 0; m_addr <= 1'b0;
          if (bus.ctl_nack) m_st <= M_STOP;
          else if (bus.ctl_start) begin
            log_bus(SR); bus.ctl_starting <= 1'b1; m_st <= M_START;
          end else if (m_read) begin
            bus.ctl_rx <= slave_data[m_k]; m_k <= m_k + 1; m_st <= M_RSHIFT;
          end else if (bus.ctl_stop) m_st <= M_STOP;
          else begin
            log_bus(bus.ctl_tx); m_st <= M_SHIFT;
          end
        end else m_cnt <= m_cnt + 1;
        M_RSHIFT: if (m_cnt == 5) begin
          m_cnt <= 0;
          if (bus.ctl_stop) m_st <= M_STOP;
          else begin
            bus.ctl_loading <= 1'b1; load_cnt <= load_cnt + 1; m_st <= M_LOAD;
          end
        end else m_cnt <= m_cnt + 1;
        M_STOP: if (m_cnt == 3) begin
          log_bus(PSTOP); bus.ctl_busy <= 1'b0; m_cnt <= 0; m_st <= M_IDLE;
        end else m_cnt <= m_cnt + 1;
        M_HANG: if (bus.ctl_stop) begin m_cnt <= 0; m_st <= M_STOP; end
        default: m_st <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      logic [32:0] e;
      e = (exp_rsp_q.size() != 0) ? exp_rsp_q.pop_front() : {1'b1, 32'hFFFF_FFFF};
      rsp_cnt++;
      $display("rsp %0d: err=%0b rdata=0x%08h", rsp_cnt, bus.rsp_err, bus.rsp_rdata);
      check("rsp", {31'd0, bus.rsp_err, bus.rsp_rdata}, {31'd0, e});
    end
  end

  task automatic send(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                      input logic [1:0] len, input logic [31:0] wd);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    bus.cmd_read = rd; bus.cmd_dev = dev; bus.cmd_reg = rg;
    bus.cmd_len = len; bus.cmd_wdata = wd; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("accept_ready_low", 64'(bus.cmd_ready), 64'd0);
    check("accept_start_high", 64'(bus.ctl_start), 64'd1);
  endtask

  task automatic wait_rsp(input int max, output int cycles, output logic stop_seen, output logic tx_chg);
    int c0;
    logic [7:0] tx0;
    c0 = rsp_cnt; tx0 = bus.ctl_tx;
    cycles = 0; stop_seen = 1'b0; tx_chg = 1'b0;
    while (rsp_cnt == c0 && cycles < max) begin
      @(negedge clk);
      cycles++;
      if (bus.ctl_stop) stop_seen = 1'b1;
      if (bus.ctl_tx !== tx0) tx_chg = 1'b1;
    end
    check("rsp_arrived", 64'(rsp_cnt != c0), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.cmd_ready), 64'd1);
    check({tag, "_zero"}, 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ctl_start,
                                bus.ctl_stop, bus.ctl_rwbit, bus.ctl_periph, bus.ctl_tx}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, n, r0, l0;
    logic ss, tc;
    bus.cmd_valid = 1'b0; bus.cmd_read = 1'b0; bus.cmd_dev = '0;
    bus.cmd_reg = '0; bus.cmd_len = '0; bus.cmd_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 2-byte write
    exp_bus_q = '{8'hA0, 8'h10, 8'hEF, 8'hBE, PSTOP};
    exp_rsp_q.push_back({1'b0, 32'h0});
    send(1'b0, 7'h50, 8'h10, 2'd1, 32'h0000BEEF);
    wait_rsp(500, cyc, ss, tc);
    check("write_bus_done", 64'(exp_bus_q.size()), 64'd0);

    // 4-byte read with repeated start
    exp_bus_q = '{8'hD0, 8'h3B, SR, 8'hD1, PSTOP};
    exp_rsp_q.push_back({1'b0, 32'h44332211});
    send(1'b1, 7'h68, 8'h3B, 2'd3, 32'h0);
    wait_rsp(500, cyc, ss, tc);
    check("read_bus_done", 64'(exp_bus_q.size()), 64'd0);

    // address NACK
    exp_bus_q = '{8'h44, PSTOP};
    exp_rsp_q.push_back({1'b1, 32'h0});
    send(1'b0, 7'h22, 8'h55, 2'd0, 32'h12345678);
    wait_rsp(500, cyc, ss, tc);
    check("nack_stop_seen", 64'(ss), 64'd1);
    check("nack_tx_unchanged", 64'(tc), 64'd0);
    check("nack_bus_done", 64'(exp_bus_q.size()), 64'd0);

    // timeout with the controller stuck before any load window
    hang_mode = 1'b1;
    exp_bus_q = '{PSTOP};
    exp_rsp_q.push_back({1'b1, 32'h0});
    send(1'b0, 7'h50, 8'h01, 2'd0, 32'h0);
    wait_rsp(2000, cyc, ss, tc);
    check("timeout_not_early", 64'(cyc >= 1000), 64'd1);
    hang_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("timeout_ready_back", 64'(bus.cmd_ready), 64'd1);

    // reset in the middle of a write, after the second load window opens
    exp_bus_q = '{8'hA0, 8'h10};
    l0 = load_cnt;
    send(1'b0, 7'h50, 8'h10, 2'd1, 32'h0000CAFE);
    n = 0;
    while (load_cnt < l0 + 2 && n < 500) begin @(negedge clk); n++; end
    check("midwrite_reached", 64'(load_cnt >= l0 + 2), 64'd1);
    repeat (3) @(negedge clk);
    check("midwrite_tx_byte0", 64'(bus.ctl_tx), 64'hFE);
    r0 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_bus_q.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_no_rsp", 64'(rsp_cnt), 64'(r0));

    exp_bus_q = '{8'hA0, 8'h20, 8'h5A, PSTOP};
    exp_rsp_q.push_back({1'b0, 32'h0});
    send(1'b0, 7'h50, 8'h20, 2'd0, 32'h0000005A);
    wait_rsp(500, cyc, ss, tc);
    check("postreset_bus_done", 64'(exp_bus_q.size()), 64'd0);

    // back-to-back with cmd_valid held high
    exp_bus_q = '{8'hA0, 8'h30, 8'h11, PSTOP, 8'hD0, 8'h40, SR, 8'hD1, PSTOP};
    exp_rsp_q.push_back({1'b0, 32'h0});
    exp_rsp_q.push_back({1'b0, 32'h00000011});
    bus.cmd_read = 1'b0; bus.cmd_dev = 7'h50; bus.cmd_reg = 8'h30;
    bus.cmd_len = 2'd0; bus.cmd_wdata = 32'h00000011; bus.cmd_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.cmd_ready && n < 100);
    bus.cmd_read = 1'b1; bus.cmd_dev = 7'h68; bus.cmd_reg = 8'h40; bus.cmd_len = 2'd0;
    n = 0;
    while (!bus.rsp_valid && n < 500) begin @(negedge clk); n++; end
    check("b2b_first_rsp", 64'(bus.rsp_valid), 64'd1);
    check("b2b_ready_during_rsp", 64'(bus.cmd_ready), 64'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ctl_start && n < 10);
    check("b2b_gap", 64'(n), 64'd2);
    bus.cmd_valid = 1'b0;
    wait_rsp(500, cyc, ss, tc);
    check("b2b_bus_done", 64'(exp_bus_q.size()), 64'd0);
    check("b2b_rsp_drained", 64'(exp_rsp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

Register-transaction sequencer that sits directly upstream of the I2C byte controller. It accepts one register-level command: a write of 1–4 bytes, or a read of 1–4 bytes, to device address / register address. It expands the command into the byte-by-byte start/stop/rwbit/periphAddr/txBuffer drive the controller expects, and returns read data plus an error flag on a single-cycle response strobe. Firmware-facing registers talk only to this block; they never drive the controller directly.

## Interface

Parameters:
- TIMEOUT_CYCLES, 2_000_000 — maximum clk cycles between consecutive progress events before the command is failed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in S_IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_read  in  1  1 = read, 0 = write.
- cmd_dev  in  7  7-bit device address.
- cmd_reg  in  8  register address.
- cmd_len  in  2  byte count minus 1 (0 → 1 byte, 3 → 4 bytes).
- cmd_wdata  in  32  write bytes; byte 0 = [7:0] is sent first.
- rsp_valid  out  1  one-cycle pulse when the command completes.
- rsp_err  out  1  valid with rsp_valid: NACK, early bus release, or timeout.
- rsp_rdata  out  32  read bytes; byte 0 in [7:0]; unread bytes are 0; 0 on writes.
- ctl_start  out  1  start/repeated-start request to the controller.
- ctl_stop  out  1  stop request to the controller.
- ctl_rwbit  out  1  R/W bit for the address phase.
- ctl_periph  out  7  device address to the controller.
- ctl_tx  out  8  next byte to transmit.
- ctl_busy  in  1  controller not idle.
- ctl_loading  in  1  controller in its ACK/load window.
- ctl_starting  in  1  controller in START/RESTART.
- ctl_nack  in  1  controller NACK flag.
- ctl_rx  in  8  last received byte.

## Operation

- Reset value of every output is 0, except cmd_ready = 1. Reset clears all internal registers, and the FSM enters S_IDLE.
- On accept, latch all cmd_* fields. cmd_* inputs are don't-care after acceptance.
- Progress event: load_rise = ctl_loading & ~ctl_loading_q. Every ctl_* input passes through a 2-flop synchroniser before use; the _q register is taken after the synchroniser.
- States and transitions:
  - S_IDLE: on accept, drive ctl_periph = dev, ctl_rwbit = 0, ctl_start = 1 → S_LAUNCH.
  - S_LAUNCH: hold ctl_start = 1 until ctl_starting is seen, then ctl_start = 0 → S_ADDR_W.
  - S_ADDR_W: on load_rise, if ctl_nack → S_FAIL; else ctl_tx = reg → S_REG.
  - S_REG: on load_rise, if ctl_nack → S_FAIL.
    - Write: ctl_tx = wdata byte 0 → S_WDATA.
    - Read: ctl_rwbit = 1, ctl_start = 1 → S_RESTART.
  - S_WDATA: on load_rise, if ctl_nack → S_FAIL. If this was the last byte (idx == len): ctl_stop = 1 → S_DRAIN. Otherwise idx++, ctl_tx = next byte.
  - S_RESTART: hold ctl_start until ctl_starting is seen, then drop it → S_ADDR_R.
  - S_ADDR_R: on load_rise, if ctl_nack → S_FAIL. Else → S_RDATA; if len == 0, assert ctl_stop now.
  - S_RDATA: on load_rise, capture ctl_rx into byte idx, then idx++. When idx reaches len, assert ctl_stop. On the fall of ctl_busy, capture the final byte into byte len → S_RESP.
  - S_DRAIN: wait for ctl_busy low → S_RESP.
  - S_FAIL: set err; drop ctl_start; assert ctl_stop; wait for ctl_busy low → S_RESP.
  - S_RESP: rsp_valid = 1 for one cycle, with rsp_err and rsp_rdata; clear ctl_stop and ctl_rwbit → S_IDLE.
- ctl_tx, ctl_start, ctl_stop and ctl_rwbit change only on a load_rise or a state entry. They stay stable through the whole loading window.
- Early release: ctl_busy falling in any state other than S_RDATA, S_DRAIN or S_FAIL sets err → S_RESP.
- Timeout: a counter restarts on every state change and every load_rise. When it reaches TIMEOUT_CYCLES, set err → S_FAIL. In S_FAIL and S_DRAIN the counter keeps running; a second expiry forces S_RESP.
- Simultaneous cmd_valid and rsp_valid cannot collide, because cmd_ready is 0 in S_RESP.
- Reset mid-transaction: outputs return to their reset values immediately. No response is emitted for the aborted command.

## Timing

- cmd_ready falls the cycle after accept. ctl_start rises in that same cycle.
- Latency from the synchronised ctl_starting to ctl_start low: 1 cycle.
- Latency from a synchronised load_rise to an updated ctl_tx/ctl_stop: 1 cycle. This is well inside the controller's load window at any prescale ≥ 4.
- rsp_valid occurs 1 cycle after S_RESP entry; cmd_ready returns the following cycle.
- idx is 2 bits and never wraps, because the len compare precedes the increment.

## Test plan

- Write: dev=0x50, reg=0x10, len=1, wdata=0x0000BEEF, slave ACKs all → bus carries A0 10 EF BE then STOP; rsp_valid with rsp_err=0 and rsp_rdata=0.
- Read: dev=0x68, reg=0x3B, len=3, slave returns 11 22 33 44 → bus carries D0 3B, repeated start, D1; rsp_rdata=0x44332211, rsp_err=0.
- Address NACK: dev=0x22 with no slave responding → ctl_stop asserted; rsp_err=1 and rsp_rdata=0; no data byte is ever driven on ctl_tx.
- Timeout: TIMEOUT_CYCLES=1000 and ctl_loading held low after start → rsp_err=1 within 2000 cycles; cmd_ready returns to 1.
- Reset mid-write (after the second load_rise) → all outputs return to reset values immediately, no rsp_valid; a following 1-byte write completes normally.
- Back-to-back: cmd_valid held high with two commands → the second is accepted only after the first rsp_valid, exactly 2 cycles later.
